// File: rtl/sphere_sched_pkg.sv
// rtl/sphere_sched_pkg.sv - shared types and defaults for the sphere area scheduler
package sphere_sched_pkg;

  localparam int RADIUS_W = 16;
  localparam int AREA_W   = 26;
  localparam int MAX_ID_W = 3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } slot_t;

endpackage

// File: rtl/sphere_area_sched_rr_arbiter.sv
// rtl/sphere_area_sched_rr_arbiter.sv - round-robin arbiter with one-hot grant and index
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] valid,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx
);

  logic [ID_W-1:0] ptr;
  logic            found;
  int              j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(ptr) + i) % N_REQ;
      if (!found && valid[j]) begin
        found     = 1'b1;
        grant_idx = ID_W'(j);
      end
    end
    if (found && !rst)
      grant = N_REQ'(1) << grant_idx;
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (|grant)
      ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
  end

endmodule

// File: rtl/sphere_area_sched.sv
// rtl/sphere_area_sched.sv - round-robin scheduler for a shared area datapath (option: SPHERE_SCHED_STATS_EN)
module sphere_area_sched #(
  parameter int N_REQ      = 4,
  parameter int ID_W       = $clog2(N_REQ),
  parameter int RADIUS_W   = sphere_sched_pkg::RADIUS_W,
  parameter int AREA_W     = sphere_sched_pkg::AREA_W,
  parameter int DP_LATENCY = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*RADIUS_W-1:0] req_radius,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      dp_en,
  output logic [RADIUS_W-1:0]       dp_radius,
  input  logic                      dp_rdy,
  input  logic [AREA_W-1:0]         dp_area,
  output logic [N_REQ-1:0]          resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic [AREA_W-1:0]         resp_area,
`ifdef SPHERE_SCHED_STATS_EN
  output logic [31:0]               stat_issued,
  output logic [31:0]               stat_completed,
  output logic [31:0]               stat_bubbles,
`endif
  output logic                      busy,
  output logic                      err
);
  import sphere_sched_pkg::*;

  state_t                state;
  slot_t                 issue_slot;
  slot_t                 sh [DP_LATENCY];
  slot_t                 exit_slot;
  logic [N_REQ-1:0]      grant;
  logic [ID_W-1:0]       grant_idx;
  logic                  accept;
  logic                  any_valid;
  logic                  pipe_empty_next;
  logic [RADIUS_W-1:0]   sel_radius;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .valid     (req_valid),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready  = grant;
  assign accept     = |grant;
  assign any_valid  = |req_valid;
  assign sel_radius = req_radius[int'(grant_idx)*RADIUS_W +: RADIUS_W];
  assign exit_slot  = sh[DP_LATENCY-1];
  assign busy       = (state != IDLE);

  // Occupancy as it will be after this cycle's shift: the exiting entry is gone.
  always_comb begin
    pipe_empty_next = ~issue_slot.valid;
    for (int i = 0; i < DP_LATENCY - 1; i++)
      if (sh[i].valid) pipe_empty_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dp_en      <= 1'b0;
      dp_radius  <= '0;
      issue_slot <= '0;
      resp_valid <= '0;
      resp_id    <= '0;
      resp_area  <= '0;
      err        <= 1'b0;
      for (int i = 0; i < DP_LATENCY; i++) sh[i] <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state <= RUN;
          dp_en <= 1'b1;
        end
        RUN: begin
          dp_en <= 1'b1;
          if (!any_valid && pipe_empty_next) state <= DRAIN;
        end
        DRAIN: begin
          state <= any_valid ? RUN : IDLE;
          dp_en <= any_valid;
        end
        default: begin
          state <= IDLE;
          dp_en <= 1'b0;
        end
      endcase

      if (accept) begin
        dp_radius        <= sel_radius;
        issue_slot.valid <= 1'b1;
        issue_slot.id    <= MAX_ID_W'(grant_idx);
      end else begin
        issue_slot <= '0;
      end

      resp_valid <= '0;
      if (dp_en) begin
        sh[0] <= issue_slot;
        for (int i = 1; i < DP_LATENCY; i++) sh[i] <= sh[i-1];
        if (exit_slot.valid) begin
          if (dp_rdy) begin
            resp_valid <= N_REQ'(1) << exit_slot.id;
            resp_id    <= ID_W'(exit_slot.id);
            resp_area  <= dp_area;
          end else begin
            err <= 1'b1;
          end
        end
      end
    end
  end

`ifdef SPHERE_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued    <= '0;
      stat_completed <= '0;
      stat_bubbles   <= '0;
    end else begin
      if (accept && stat_issued != '1) stat_issued <= stat_issued + 32'd1;
      if (|resp_valid && stat_completed != '1) stat_completed <= stat_completed + 32'd1;
      if (dp_en && !issue_slot.valid && stat_bubbles != '1) stat_bubbles <= stat_bubbles + 32'd1;
    end
  end
`endif

endmodule
